load_store_unit: RTL and testbench

- Initiator-side counterpart to the unified byte memory.
- Accepts one load/store request at a time from the pipeline MEM stage using RV32I funct3 encoding, and drives the memory's read port and its aligned-only write port.
- Sign- or zero-extends load data and returns a one-cycle response.
- Splits misaligned stores into byte writes, because the memory rejects misaligned writes.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/load_store_unit_load_extend.sv | 29 ++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 codes, write widths, FSM encoding
// and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WIDTH_BYTE = 4'd1;
  localparam logic [3:0] WIDTH_HALF = 4'd2;
  localparam logic [3:0] WIDTH_WORD = 4'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_SPLIT = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return WIDTH_BYTE;
      2'b01:   return WIDTH_HALF;
      default: return WIDTH_WORD;
    endcase
  endfunction

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load-data extension: picks the low 1/2/4 bytes of the raw read and
// sign- or zero-extends them according to the load funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic signed [7:0]  raw_b;
  logic signed [15:0] raw_h;

  assign raw_b = raw[7:0];
  assign raw_h = raw[15:0];

  always_comb begin
    ext = '0;
    case (funct3)
      F3_B:    ext = 32'(raw_b);
      F3_H:    ext = 32'(raw_h);
      F3_W:    ext = raw;
      F3_BU:   ext = {24'b0, raw[7:0]};
      F3_HU:   ext = {16'b0, raw[15:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of the unified byte memory.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned SH/SW into byte writes; otherwise they fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH_IN_BYTE = 16384,
  parameter int ADDR_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr_read,
  input  logic [31:0]           mem_read_data,
  output logic                  mem_write_en,
  output logic [3:0]            mem_write_width,
  output logic [ADDR_WIDTH-1:0] mem_addr_write,
  output logic [31:0]           mem_write_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH_IN_BYTE);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic [2:0]            funct3_q;
  logic                  store_q;
  logic                  err_q;
  logic [3:0]            size_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]            idx_q;
`endif

  logic [ADDR_WIDTH:0]   end_addr;
  logic                  misal;
  logic                  exec_err;
  logic [31:0]           ext_data;

  // One bit wider than the address so a wrapped access still trips the range check.
  assign end_addr = {1'b0, addr_q} + {{(ADDR_WIDTH-3){1'b0}}, size_q};
  assign misal    = ((size_q == WIDTH_HALF) && addr_q[0]) ||
                    ((size_q == WIDTH_WORD) && (addr_q[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
  assign exec_err = !f3_legal(store_q, funct3_q) || (end_addr > DEPTH_L);
`else
  assign exec_err = !f3_legal(store_q, funct3_q) || (end_addr > DEPTH_L) || (store_q && misal);
`endif

  load_extend u_load_extend (
    .raw    (mem_read_data),
    .funct3 (funct3_q),
    .ext    (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      idx_q    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            store_q  <= req_is_store;
            size_q   <= f3_size(req_funct3);
            err_q    <= 1'b0;
            data_q   <= '0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          err_q <= exec_err;
          if (!exec_err && !store_q) data_q <= ext_data;
          state <= ST_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (!exec_err && store_q && misal) begin
            idx_q <= 2'd1;
            state <= ST_SPLIT;
          end
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_SPLIT: begin
          idx_q <= idx_q + 2'd1;
          if ({2'b00, idx_q} == size_q - 4'd1) state <= ST_RESP;
        end
`endif
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (state == ST_IDLE);
  assign resp_valid    = (state == ST_RESP);
  assign resp_data     = resp_valid ? data_q : 32'h0;
  assign resp_err      = resp_valid && err_q;
  assign mem_addr_read = addr_q;

  // Write port is driven only while a store is actually being performed.
  always_comb begin
    mem_write_en    = 1'b0;
    mem_write_width = '0;
    mem_addr_write  = '0;
    mem_write_data  = '0;
    case (state)
      ST_EXEC: begin
        if (store_q && !exec_err) begin
          mem_write_en   = 1'b1;
          mem_addr_write = addr_q;
          if (misal) begin
            mem_write_width = WIDTH_BYTE;
            mem_write_data  = {24'b0, wdata_q[7:0]};
          end else begin
            mem_write_width = size_q;
            mem_write_data  = wdata_q;
          end
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_SPLIT: begin
        mem_write_en    = 1'b1;
        mem_write_width = WIDTH_BYTE;
        mem_addr_write  = addr_q + ADDR_WIDTH'(idx_q);
        mem_write_data  = {24'b0, wdata_q[{idx_q, 3'b000} +: 8]};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a byte-array reference model;
// honours LSU_MISALIGN_SPLIT_EN the same way as the design.
module tb_load_store_unit;

  localparam int DEPTH = 16384;
  localparam int AW    = 32;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_is_store;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic [AW-1:0] mem_addr_read;
  logic [31:0]   mem_read_data;
  logic          mem_write_en;
  logic [3:0]    mem_write_width;
  logic [AW-1:0] mem_addr_write;
  logic [31:0]   mem_write_data;

  load_store_unit #(.MEM_DEPTH_IN_BYTE(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr_read(mem_addr_read), .mem_read_data(mem_read_data),
    .mem_write_en(mem_write_en), .mem_write_width(mem_write_width),
    .mem_addr_write(mem_addr_write), .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  // env_mem is the memory the DUT talks to; ref_mem is what the model says it should hold.
  logic [7:0] env_mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 4; i++)
      if (longint'(mem_addr_read) + i < DEPTH)
        mem_read_data[8*i +: 8] = env_mem[int'(mem_addr_read) + i];
  end

  always @(posedge clk)
    if (mem_write_en)
      for (int i = 0; i < 4; i++)
        if (i < int'(mem_write_width) && longint'(mem_addr_write) + i < DEPTH)
          env_mem[int'(mem_addr_write) + i] <= mem_write_data[8*i +: 8];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          we;
    int          width;
    logic [31:0] waddr;
    logic [31:0] wdata;
    bit          rv;
    logic [31:0] rdata;
    bit          rerr;
  } step_t;

  step_t exp_q[$];

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned addr, input int n);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
    if (f3[2] == 1'b0 && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
    return v[31:0];
  endfunction

  // Build the per-cycle expectation list for one request and update ref_mem.
  task automatic model_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int n;
    bit legal, oob, mis, err;
    step_t s;
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    oob   = (longint'(addr) + n) > DEPTH;
    mis   = (addr % n) != 0;
    err   = !legal || oob || (st && mis && !SPLIT_EN);
    exp_q.delete();
    s = '{we: 0, width: 0, waddr: 0, wdata: 0, rv: 0, rdata: 0, rerr: 0};
    if (err || !st) begin
      exp_q.push_back(s);
      s.rv = 1; s.rerr = err; s.rdata = err ? 32'h0 : model_load(f3, addr, n);
      exp_q.push_back(s);
    end else if (!mis) begin
      s.we = 1; s.width = n; s.waddr = addr; s.wdata = wdata;
      exp_q.push_back(s);
      for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'((wdata >> (8 * i)) & 32'hFF);
      s = '{we: 0, width: 0, waddr: 0, wdata: 0, rv: 1, rdata: 0, rerr: 0};
      exp_q.push_back(s);
    end else begin
      for (int i = 0; i < n; i++) begin
        s.we = 1; s.width = 1; s.waddr = addr + i; s.wdata = (wdata >> (8 * i)) & 32'hFF;
        exp_q.push_back(s);
        ref_mem[addr + i] = s.wdata[7:0];
      end
      s = '{we: 0, width: 0, waddr: 0, wdata: 0, rv: 1, rdata: 0, rerr: 0};
      exp_q.push_back(s);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got_data,
                         output logic got_err);
    got_data = '0;
    got_err  = 1'b0;
    model_txn(st, f3, addr, wdata);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    foreach (exp_q[j]) begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("mem_write_en", 32'(mem_write_en), 32'(exp_q[j].we));
      if (exp_q[j].we) begin
        check("mem_write_width", 32'(mem_write_width), 32'(exp_q[j].width));
        check("mem_addr_write", mem_addr_write, exp_q[j].waddr);
        check("mem_write_data", mem_write_data, exp_q[j].wdata);
      end
      check("resp_valid", 32'(resp_valid), 32'(exp_q[j].rv));
      if (exp_q[j].rv) begin
        check("resp_data", resp_data, exp_q[j].rdata);
        check("resp_err", 32'(resp_err), 32'(exp_q[j].rerr));
        got_data = resp_data;
        got_err  = resp_err;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_write_en", 32'(mem_write_en), 32'd0);
    check("rst_mem_write_width", 32'(mem_write_width), 32'd0);
    check("rst_mem_addr_read", mem_addr_read, 32'd0);
    check("rst_mem_addr_write", mem_addr_write, 32'd0);
    check("rst_mem_write_data", mem_write_data, 32'd0);
  endtask

  initial begin
    logic [31:0] d, a, w;
    logic        e, st;
    logic [2:0]  f3;
    int          nbad;

    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with literal expectations pinning the model.
    run_txn(1, 3'b010, 32'h10, 32'hDEADBEEF, d, e);
    run_txn(0, 3'b010, 32'h10, 32'h0, d, e);
    check("lw_literal", d, 32'hDEADBEEF);
    check("lw_err_literal", 32'(e), 32'd0);
    run_txn(1, 3'b000, 32'h20, 32'h80, d, e);
    run_txn(0, 3'b000, 32'h20, 32'h0, d, e);
    check("lb_literal", d, 32'hFFFFFF80);
    run_txn(0, 3'b100, 32'h20, 32'h0, d, e);
    check("lbu_literal", d, 32'h00000080);
    run_txn(1, 3'b010, 32'h31, 32'h11223344, d, e);
    check("sw_mis_err_literal", 32'(e), SPLIT_EN ? 32'd0 : 32'd1);
    if (SPLIT_EN) begin
      run_txn(0, 3'b010, 32'h31, 32'h0, d, e);
      check("lw_mis_literal", d, 32'h11223344);
    end
    run_txn(0, 3'b010, DEPTH - 2, 32'h0, d, e);
    check("lw_oob_err_literal", 32'(e), 32'd1);
    check("lw_oob_data_literal", d, 32'h0);
    run_txn(0, 3'b011, 32'h40, 32'h0, d, e);
    check("bad_f3_err_literal", 32'(e), 32'd1);
    run_txn(1, 3'b100, 32'h40, 32'h55, d, e);
    run_txn(0, 3'b010, DEPTH - 4, 32'h0, d, e);
    run_txn(1, 3'b000, DEPTH - 1, 32'hA5, d, e);
    run_txn(1, 3'b001, DEPTH - 1, 32'hBEEF, d, e);
    run_txn(0, 3'b010, 32'hFFFFFFFE, 32'h0, d, e);
    check("wrap_err_literal", 32'(e), 32'd1);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      st = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       a = $urandom_range(0, 63);
        1:       a = DEPTH - $urandom_range(1, 6);
        2:       a = $urandom;
        default: a = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        f3 = 3'($urandom_range(0, 2));
        if (!st && f3 != 3'd2 && $urandom_range(0, 1) == 1) f3 = f3 | 3'b100;
      end
      w = $urandom;
      run_txn(st, f3, a, w, d, e);
    end

    if (SPLIT_EN) begin
      // Reset while the third byte of a split store is being written.
      ref_mem[32'h51] = 8'hD4;
      ref_mem[32'h52] = 8'hC3;
      check("req_ready_pre_abort", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h51; req_wdata = 32'hA1B2C3D4;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_txn(0, 3'b010, 32'h51, 32'h0, d, e);
    end

    nbad = 0;
    for (int i = 0; i < DEPTH; i++) if (env_mem[i] !== ref_mem[i]) nbad++;
    check("mem_image_bad_bytes", 32'(nbad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
